// File: rtl/ctrl_store_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_store_pkg
// Shared gobou control-chain definitions: word/address/count widths, the
// start/valid/stop control bus and the ctrl_store state encoding.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ctrl_store_pkg;

  localparam int DWIDTH  = 16;
  localparam int MEMSIZE = 12;
  localparam int LWIDTH  = 10;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_bus_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } ctrl_store_state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_store_if.sv
// ----------------------------------------------------------------------------
// ctrl_store_if
// Groups the ReLU-side inputs and the output-memory / forwarded-control
// outputs of ctrl_store. master = driver of the chain, slave = ctrl_store.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ctrl_store_if
  import ctrl_store_pkg::*;
();

  ctrl_bus_t                 in_ctrl;
  logic signed [DWIDTH-1:0]  in_data;
  logic [MEMSIZE-1:0]        out_base;
  logic [LWIDTH-1:0]         total_out;

  ctrl_bus_t                 out_ctrl;
  logic                      mem_we;
  logic [MEMSIZE-1:0]        mem_addr;
  logic signed [DWIDTH-1:0]  mem_wdata;
  logic                      busy;
  logic                      err;

  modport master (
    output in_ctrl, in_data, out_base, total_out,
    input  out_ctrl, mem_we, mem_addr, mem_wdata, busy, err
  );

  modport slave (
    input  in_ctrl, in_data, out_base, total_out,
    output out_ctrl, mem_we, mem_addr, mem_wdata, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/store_addr_gen.sv
// ----------------------------------------------------------------------------
// store_addr_gen
// Holds the latched base address and the neuron index. Presents the address
// for the current cycle's write (new base when loading) and the index value
// after this cycle's load/increment, used for the final-count check.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_addr_gen
  import ctrl_store_pkg::*;
(
  input  logic               clk,
  input  logic               xrst,
  input  logic               load,
  input  logic               inc,
  input  logic [MEMSIZE-1:0] base_in,
  output logic [MEMSIZE-1:0] addr,
  output logic [LWIDTH-1:0]  count
);

  logic [MEMSIZE-1:0] base_q;
  logic [LWIDTH-1:0]  idx_q;
  logic [LWIDTH-1:0]  idx_cur;

  // A load restarts the run, so a coincident write uses the new base at idx 0.
  always_comb begin
    idx_cur = load ? '0 : idx_q;
    addr    = (load ? base_in : base_q) + {{(MEMSIZE-LWIDTH){1'b0}}, idx_cur};
    count   = idx_cur + {{(LWIDTH-1){1'b0}}, inc};
  end

  // Base and index registers; index wraps silently at 2^LWIDTH.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      base_q <= '0;
      idx_q  <= '0;
    end else begin
      if (load)
        base_q <= base_in;
      if (load || inc)
        idx_q <= count;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_store.sv
// ----------------------------------------------------------------------------
// ctrl_store
// Terminal stage of the gobou control chain: turns each valid activated word
// into an output-memory write at base+idx and forwards the control bus one
// cycle late so the chain head can acknowledge on the forwarded stop.
// Optional macro: GOBOU_STORE_CHECK_EN enables the sticky count-mismatch err.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ctrl_store
  import ctrl_store_pkg::*;
(
  input  logic         clk,
  input  logic         xrst,
  ctrl_store_if.slave  bus
);

  ctrl_store_state_t  state_q;
  ctrl_store_state_t  state_d;
  logic               accept_start;
  logic               accept_stop;
  logic               write;
  logic               valid_idle;
  logic [MEMSIZE-1:0] gen_addr;
  logic [LWIDTH-1:0]  gen_count;

  ctrl_bus_t                out_ctrl_q;
  logic                     mem_we_q;
  logic [MEMSIZE-1:0]       mem_addr_q;
  logic signed [DWIDTH-1:0] mem_wdata_q;
  logic                     busy_q;

  store_addr_gen u_addr_gen (
    .clk     (clk),
    .xrst    (xrst),
    .load    (accept_start),
    .inc     (write),
    .base_in (bus.out_base),
    .addr    (gen_addr),
    .count   (gen_count)
  );

  // State register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next state and accepted-event decode; start beats a coincident stop.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    accept_stop  = 1'b0;
    write        = 1'b0;
    valid_idle   = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_idle = bus.in_ctrl.valid && !bus.in_ctrl.start;
        if (bus.in_ctrl.start) begin
          accept_start = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        write = bus.in_ctrl.valid;
        if (bus.in_ctrl.start) begin
          accept_start = 1'b1;
        end else if (bus.in_ctrl.stop) begin
          accept_stop = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered write port, forwarded control and busy (high in RUN/DONE).
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      out_ctrl_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_ctrl_q.start <= accept_start;
      out_ctrl_q.valid <= write;
      out_ctrl_q.stop  <= accept_stop;
      mem_we_q         <= write;
      if (write) begin
        mem_addr_q  <= gen_addr;
        mem_wdata_q <= bus.in_data;
      end
      busy_q <= (state_d == S_RUN) || (state_d == S_DONE);
    end
  end

  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

`ifdef GOBOU_STORE_CHECK_EN
  logic [LWIDTH-1:0] total_q;
  logic              err_q;

  // Sticky err: final count mismatch at stop, or a valid seen while idle;
  // cleared by the next accepted start.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept_start) begin
        total_q <= bus.total_out;
        err_q   <= 1'b0;
      end else if ((accept_stop && (gen_count != total_q)) || valid_idle) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_store.sv
// ----------------------------------------------------------------------------
// tb_ctrl_store
// Directed self-checking bench for ctrl_store.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_store;
  import ctrl_store_pkg::*;

`ifdef GOBOU_STORE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk;
  logic xrst;
  int   checks;
  int   failures;

  ctrl_store_if bus ();

  ctrl_store dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then wait until just after the capturing edge.
  task automatic cyc(input logic st, input logic va, input logic sp,
                     input logic [15:0] d, input logic [11:0] base,
                     input logic [9:0] tot);
    bus.in_ctrl.start = st;
    bus.in_ctrl.valid = va;
    bus.in_ctrl.stop  = sp;
    bus.in_data       = d;
    bus.out_base      = base;
    bus.total_out     = tot;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 12'h0, 10'd0);
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    idle();
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_ctrl, bus.busy, bus.err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h ctrl=%b busy=%b err=%b, want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_ctrl, bus.busy, bus.err);
    end
    xrst = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h100, 10'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.out_ctrl !== 3'b100 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL basic_start: busy=%b ctrl=%b we=%b, want 1 100 0", bus.busy, bus.out_ctrl, bus.mem_we);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'(i + 1), 12'h0, 10'd0);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'(12'h100 + i) ||
          bus.mem_wdata !== 16'(i + 1) || bus.out_ctrl !== 3'b010) begin
        failures++;
        $display("FAIL basic_write%0d: we=%b addr=%h data=%h ctrl=%b, want 1 %h %h 010",
                 i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_ctrl, 12'h100 + i, i + 1);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    checks++;
    if (bus.out_ctrl !== 3'b001 || bus.busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL basic_stop: ctrl=%b busy=%b we=%b err=%b, want 001 1 0 0",
               bus.out_ctrl, bus.busy, bus.mem_we, bus.err);
    end
    idle();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_ctrl !== 3'b000 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: busy=%b ctrl=%b err=%b, want 0 000 0", bus.busy, bus.out_ctrl, bus.err);
    end
  endtask

  task automatic test_stop_with_last();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h100, 10'd3);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 12'h0, 10'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0011, 12'h0, 10'd0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0012, 12'h0, 10'd0);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h102 || bus.mem_wdata !== 16'h0012 ||
        bus.out_ctrl !== 3'b011 || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL stop_last: we=%b addr=%h data=%h ctrl=%b busy=%b err=%b, want 1 102 0012 011 1 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_ctrl, bus.busy, bus.err);
    end
    idle();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL stop_last_after: busy=%b we=%b err=%b, want 0 0 0", bus.busy, bus.mem_we, bus.err);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [4];
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'hFFE, 10'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'hA0 + 16'(i), 12'h0, 10'd0);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_addr[i]) begin
        failures++;
        $display("FAIL wrap%0d: we=%b addr=%h, want 1 %h", i, bus.mem_we, bus.mem_addr, exp_addr[i]);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    checks++;
    if (bus.err !== 1'b0 || bus.out_ctrl !== 3'b001) begin
      failures++;
      $display("FAIL wrap_stop: err=%b ctrl=%b, want 0 001", bus.err, bus.out_ctrl);
    end
    idle();
  endtask

  task automatic test_mismatch();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h040, 10'd5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 16'(i), 12'h0, 10'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    checks++;
    if (bus.err !== CHK) begin
      failures++;
      $display("FAIL mismatch_done: err=%b, want %b", bus.err, CHK);
    end
    idle();
    checks++;
    if (bus.err !== CHK || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_hold: err=%b busy=%b, want %b 0", bus.err, bus.busy, CHK);
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h040, 10'd0);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_clear: err=%b, want 0", bus.err);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL zero_run: err=%b, want 0", bus.err);
    end
    idle();
    cyc(1'b0, 1'b1, 1'b0, 16'h55, 12'h0, 10'd0);
    checks++;
    if (bus.err !== CHK || bus.mem_we !== 1'b0 || bus.out_ctrl !== 3'b000) begin
      failures++;
      $display("FAIL idle_valid: err=%b we=%b ctrl=%b, want %b 0 000", bus.err, bus.mem_we, bus.out_ctrl, CHK);
    end
    idle();
  endtask

  task automatic test_restart();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h010, 10'd3);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: err=%b, want 0", bus.err);
    end
    cyc(1'b0, 1'b1, 1'b0, 16'h0021, 12'h0, 10'd0);
    checks++;
    if (bus.mem_addr !== 12'h010 || bus.mem_wdata !== 16'h0021) begin
      failures++;
      $display("FAIL restart_w0: addr=%h data=%h, want 010 0021", bus.mem_addr, bus.mem_wdata);
    end
    cyc(1'b0, 1'b1, 1'b0, 16'h0022, 12'h0, 10'd0);
    checks++;
    if (bus.mem_addr !== 12'h011 || bus.mem_wdata !== 16'h0022) begin
      failures++;
      $display("FAIL restart_w1: addr=%h data=%h, want 011 0022", bus.mem_addr, bus.mem_wdata);
    end
    // start+valid+stop: start wins, stop dropped, valid is word 0 of new run
    cyc(1'b1, 1'b1, 1'b1, 16'h0023, 12'h200, 10'd2);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h200 || bus.mem_wdata !== 16'h0023 ||
        bus.out_ctrl !== 3'b110 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_new: we=%b addr=%h data=%h ctrl=%b busy=%b, want 1 200 0023 110 1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_ctrl, bus.busy);
    end
    cyc(1'b0, 1'b1, 1'b0, 16'h0024, 12'h0, 10'd0);
    checks++;
    if (bus.mem_addr !== 12'h201 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_w2: addr=%h busy=%b, want 201 1", bus.mem_addr, bus.busy);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    checks++;
    if (bus.err !== 1'b0 || bus.out_ctrl !== 3'b001) begin
      failures++;
      $display("FAIL restart_stop: err=%b ctrl=%b, want 0 001", bus.err, bus.out_ctrl);
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h300, 10'd6);
    cyc(1'b0, 1'b1, 1'b0, 16'h0001, 12'h0, 10'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0002, 12'h0, 10'd0);
    bus.in_ctrl.valid = 1'b1;
    bus.in_data       = 16'h0003;
    #2;
    xrst = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.mem_addr !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: we=%b busy=%b err=%b addr=%h, want 0 0 0 000",
               bus.mem_we, bus.busy, bus.err, bus.mem_addr);
    end
    idle();
    xrst = 1'b1;
    idle();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 12'h050, 10'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0077, 12'h0, 10'd0);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h050 || bus.mem_wdata !== 16'h0077) begin
      failures++;
      $display("FAIL reset_fresh: we=%b addr=%h data=%h, want 1 050 0077",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'h0, 12'h0, 10'd0);
    idle();
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_fresh_end: busy=%b err=%b, want 0 0", bus.busy, bus.err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    xrst     = 1'b1;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.out_base  = '0;
    bus.total_out = '0;
    #2;
    test_reset();
    test_basic();
    test_stop_with_last();
    test_wrap();
    test_mismatch();
    test_restart();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
